// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: buffers entered digits, compares them against an
// internally stored code, and manages the unlock window, in-window code
// reprogramming, consecutive-failure counting and the timed alarm lockout.
module code_lock_ctrl #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                            MAX_FAILS      = 3,
    parameter int                            UNLOCK_CYCLES  = 8,
    parameter int                            LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             digit_vld,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic                             cancel,
    output logic                             open,
    output logic                             alarm,
    output logic [$clog2(CODE_LEN+1)-1:0]    entered_cnt,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic                             pw_updated,
    output logic [2:0]                       state_o
);

    localparam int CODE_W  = DIGIT_W * CODE_LEN;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  TMR_UNLOCK   = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LOCKOUT  = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SETPW   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_open;
    logic                r_alarm;
    logic [CNT_W-1:0]    r_cnt;
    logic [FAIL_W-1:0]   r_fail;
    logic                r_pw_updated;
    logic [CODE_W-1:0]   r_buf;
    logic [CODE_W-1:0]   r_stored;
    logic [TMR_W-1:0]    r_timer;

    logic                w_cnt_full;
    logic                w_timer_zero;
    logic [CODE_W-1:0]   w_buf_shift;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic [TMR_W-1:0]    w_timer_dec;

    // Shift-in of the new digit keeps the most recent CODE_LEN digits, first digit ending in the MSBs.
    assign w_buf_shift  = CODE_W'({r_buf, digit});
    assign w_cnt_full   = (r_cnt == CNT_FULL);
    assign w_timer_zero = (r_timer == '0);
    assign w_fail_inc   = r_fail + FAIL_W'(1);
    assign w_timer_dec  = r_timer - TMR_W'(1);

    // Controller FSM with all outputs held in registers; strobe priority is cancel > enter > digit_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_open       <= 1'b0;
            r_alarm      <= 1'b0;
            r_cnt        <= '0;
            r_fail       <= '0;
            r_pw_updated <= 1'b0;
            r_buf        <= '0;
            r_timer      <= '0;
            // NOTE: the stored code is an ordinary register with a reset value, not a RAM, so resetting it is legal and cheap.
            r_stored     <= DEFAULT_CODE;
        end else begin
            // NOTE: every state register uses <= so all branches see the pre-edge values regardless of statement order.
            r_pw_updated <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cancel) begin
                        r_buf <= '0;
                        r_cnt <= '0;
                    end else if (enter) begin
                        r_state <= ST_CHECK;
                    end else if (digit_vld && !w_cnt_full) begin
                        r_buf <= w_buf_shift;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    r_buf <= '0;
                    r_cnt <= '0;
                    if (w_cnt_full && (r_buf == r_stored)) begin
                        r_state <= ST_OPEN;
                        r_open  <= 1'b1;
                        r_alarm <= 1'b0;
                        r_fail  <= '0;
                        r_timer <= TMR_UNLOCK;
                    end else begin
                        r_fail <= w_fail_inc;
                        if (w_fail_inc == FAIL_LIMIT) begin
                            r_state <= ST_LOCKOUT;
                            r_alarm <= 1'b1;
                            r_timer <= TMR_LOCKOUT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_OPEN: begin
                    if (enter) begin
                        r_state <= ST_SETPW;
                        r_open  <= 1'b0;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                        r_timer <= TMR_UNLOCK;
                    end else if (w_timer_zero) begin
                        r_state <= ST_IDLE;
                        r_open  <= 1'b0;
                    end else begin
                        r_timer <= w_timer_dec;
                    end
                end
                ST_SETPW: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end else if (enter && w_cnt_full) begin
                        r_stored     <= r_buf;
                        r_pw_updated <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_buf        <= '0;
                        r_cnt        <= '0;
                    end else if (w_timer_zero) begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_timer <= w_timer_dec;
                        if (!enter && digit_vld && !w_cnt_full) begin
                            r_buf <= w_buf_shift;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (w_timer_zero) begin
                        r_state <= ST_IDLE;
                        r_fail  <= '0;
                    end else begin
                        r_timer <= w_timer_dec;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_open  <= 1'b0;
                    r_alarm <= 1'b0;
                    r_cnt   <= '0;
                    r_fail  <= '0;
                    r_buf   <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign open        = r_open;
    assign alarm       = r_alarm;
    assign entered_cnt = r_cnt;
    assign fail_cnt    = r_fail;
    assign pw_updated  = r_pw_updated;
    assign state_o     = r_state;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl with default parameters.
// Expected values are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       digit_vld = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       cancel = 1'b0;
    logic       open;
    logic       alarm;
    logic [2:0] entered_cnt;
    logic [1:0] fail_cnt;
    logic       pw_updated;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    int sb[$];

    code_lock_ctrl #(
        .DIGIT_W(4), .CODE_LEN(4), .DEFAULT_CODE(16'h1234),
        .MAX_FAILS(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_vld(digit_vld), .digit(digit),
        .enter(enter), .cancel(cancel), .open(open), .alarm(alarm),
        .entered_cnt(entered_cnt), .fail_cnt(fail_cnt),
        .pw_updated(pw_updated), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic int pop_exp();
        if (sb.size() == 0) return -1;
        return sb.pop_front();
    endfunction

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit = d; digit_vld = 1'b1; tick(); digit_vld = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1; tick(); enter = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press_digit(code[15-4*i -: 4]);
        press_enter();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (state_o !== 3'd0 && g < 60) begin tick(); g++; end
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL %s_wait_idle: state_o=%0d expected 0 within 60 cycles", tag, state_o); end
    endtask

    task automatic test_reset();
        int ev;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL rst_open: got %0d expected %0d", open, ev); end
        ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL rst_alarm: got %0d expected %0d", alarm, ev); end
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL rst_cnt: got %0d expected %0d", entered_cnt, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL rst_fail: got %0d expected %0d", fail_cnt, ev); end
        ev = pop_exp(); checks++; if (pw_updated !== ev) begin errors++; $display("FAIL rst_pw: got %0d expected %0d", pw_updated, ev); end
        tick(); tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_open();
        int ev, n;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(i);
            press_digit(4'(i));
            ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL open_cnt: got %0d expected %0d", entered_cnt, ev); end
        end
        sb.push_back(1); sb.push_back(0);
        press_enter();
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL open_check_state: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL open_early: got %0d expected %0d", open, ev); end
        sb.push_back(1); sb.push_back(0); sb.push_back(8); sb.push_back(0);
        tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL open_latency: got %0d expected %0d", open, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL open_fail: got %0d expected %0d", fail_cnt, ev); end
        n = 0;
        while (open === 1'b1 && n < 20) begin n++; tick(); end
        ev = pop_exp(); checks++; if (n !== ev) begin errors++; $display("FAIL open_width: got %0d cycles expected %0d", n, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL open_end_state: got %0d expected %0d", state_o, ev); end
    endtask

    task automatic test_lockout();
        int ev, n;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(i); sb.push_back(i == 3 ? 4 : 0); sb.push_back(i == 3 ? 1 : 0);
            enter_code(16'h1235);
            tick();
            ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL lock_fail%0d: got %0d expected %0d", i, fail_cnt, ev); end
            ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL lock_state%0d: got %0d expected %0d", i, state_o, ev); end
            ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL lock_alarm%0d: got %0d expected %0d", i, alarm, ev); end
        end
        sb.push_back(16); sb.push_back(0); sb.push_back(0); sb.push_back(1); sb.push_back(0);
        digit = 4'd7; digit_vld = 1'b1; n = 0;
        while (state_o === 3'd4 && n < 40) begin n++; tick(); end
        digit_vld = 1'b0;
        ev = pop_exp(); checks++; if (n !== ev) begin errors++; $display("FAIL lock_len: got %0d cycles expected %0d", n, ev); end
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL lock_ignored: got %0d expected %0d", entered_cnt, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL lock_fail_clr: got %0d expected %0d", fail_cnt, ev); end
        ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL lock_alarm_hold: got %0d expected %0d", alarm, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL lock_exit: got %0d expected %0d", state_o, ev); end
        sb.push_back(0); sb.push_back(1);
        enter_code(16'h1234);
        tick();
        ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL lock_alarm_clr: got %0d expected %0d", alarm, ev); end
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL lock_reopen: got %0d expected %0d", open, ev); end
        wait_idle("lock");
    endtask

    task automatic test_reprogram();
        int ev;
        enter_code(16'h1234);
        tick();
        sb.push_back(3); sb.push_back(0);
        press_enter();
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL pgm_setpw: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL pgm_open_drop: got %0d expected %0d", open, ev); end
        sb.push_back(1); sb.push_back(0); sb.push_back(0);
        enter_code(16'h9876);
        ev = pop_exp(); checks++; if (pw_updated !== ev) begin errors++; $display("FAIL pgm_pulse: got %0d expected %0d", pw_updated, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL pgm_idle: got %0d expected %0d", state_o, ev); end
        tick();
        ev = pop_exp(); checks++; if (pw_updated !== ev) begin errors++; $display("FAIL pgm_pulse_end: got %0d expected %0d", pw_updated, ev); end
        sb.push_back(0); sb.push_back(1);
        enter_code(16'h1234);
        tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL pgm_old_rejected: got %0d expected %0d", open, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL pgm_old_fail: got %0d expected %0d", fail_cnt, ev); end
        sb.push_back(1);
        enter_code(16'h9876);
        tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL pgm_new_opens: got %0d expected %0d", open, ev); end
        wait_idle("pgm");
    endtask

    task automatic test_setpw_timeout();
        int ev, n;
        apply_reset();
        enter_code(16'h1234);
        tick();
        press_enter();
        n = (state_o === 3'd3) ? 1 : 0;
        press_digit(4'd5); if (state_o === 3'd3) n++;
        press_digit(4'd6); if (state_o === 3'd3) n++;
        sb.push_back(3); sb.push_back(2);
        press_enter(); if (state_o === 3'd3) n++;
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL to_short_enter: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL to_cnt: got %0d expected %0d", entered_cnt, ev); end
        sb.push_back(8); sb.push_back(0); sb.push_back(0);
        for (int g = 0; g < 30 && state_o === 3'd3; g++) begin tick(); if (state_o === 3'd3) n++; end
        ev = pop_exp(); checks++; if (n !== ev) begin errors++; $display("FAIL to_len: got %0d cycles expected %0d", n, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL to_idle: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL to_cnt_clr: got %0d expected %0d", entered_cnt, ev); end
        sb.push_back(1);
        enter_code(16'h1234);
        tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL to_code_kept: got %0d expected %0d", open, ev); end
        wait_idle("to");
        sb.push_back(1); sb.push_back(0);
        press_digit(4'd1); press_digit(4'd2); press_enter();
        tick();
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL short_fail: got %0d expected %0d", fail_cnt, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL short_state: got %0d expected %0d", state_o, ev); end
    endtask

    task automatic test_priority();
        int ev;
        sb.push_back(4); sb.push_back(1);
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4); press_digit(4'd7);
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL sat_cnt: got %0d expected %0d", entered_cnt, ev); end
        press_enter(); tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL sat_open: got %0d expected %0d", open, ev); end
        wait_idle("sat");
        sb.push_back(1); sb.push_back(1);
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
        digit = 4'd4; digit_vld = 1'b1; enter = 1'b1; tick(); digit_vld = 1'b0; enter = 1'b0;
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL de_check: got %0d expected %0d", state_o, ev); end
        tick();
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL de_dropped: got %0d expected %0d", fail_cnt, ev); end
        sb.push_back(0); sb.push_back(0); sb.push_back(1); sb.push_back(0);
        press_digit(4'd1); press_digit(4'd2);
        cancel = 1'b1; enter = 1'b1; tick(); cancel = 1'b0; enter = 1'b0;
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL ce_state: got %0d expected %0d", state_o, ev); end
        ev = pop_exp(); checks++; if (entered_cnt !== ev) begin errors++; $display("FAIL ce_cnt: got %0d expected %0d", entered_cnt, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL ce_fail: got %0d expected %0d", fail_cnt, ev); end
        tick();
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL ce_no_check: got %0d expected %0d", state_o, ev); end
    endtask

    task automatic test_async_reset();
        int ev;
        enter_code(16'h1234);
        tick(); tick(); tick();
        sb.push_back(1); sb.push_back(0); sb.push_back(0);
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL ar_open_pre: got %0d expected %0d", open, ev); end
        #3 rst_n = 1'b0; #1;
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL ar_open: got %0d expected %0d", open, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL ar_open_state: got %0d expected %0d", state_o, ev); end
        tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin enter_code(16'h4321); tick(); end
        tick(); tick();
        sb.push_back(1); sb.push_back(0); sb.push_back(0); sb.push_back(0);
        ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL ar_alarm_pre: got %0d expected %0d", alarm, ev); end
        #3 rst_n = 1'b0; #1;
        ev = pop_exp(); checks++; if (alarm !== ev) begin errors++; $display("FAIL ar_alarm: got %0d expected %0d", alarm, ev); end
        ev = pop_exp(); checks++; if (fail_cnt !== ev) begin errors++; $display("FAIL ar_fail: got %0d expected %0d", fail_cnt, ev); end
        ev = pop_exp(); checks++; if (state_o !== ev) begin errors++; $display("FAIL ar_lock_state: got %0d expected %0d", state_o, ev); end
        tick(); rst_n = 1'b1; tick();
        enter_code(16'h1234); tick();
        press_enter();
        sb.push_back(1);
        enter_code(16'hABCD);
        ev = pop_exp(); checks++; if (pw_updated !== ev) begin errors++; $display("FAIL ar_pgm: got %0d expected %0d", pw_updated, ev); end
        apply_reset();
        sb.push_back(1);
        enter_code(16'h1234); tick();
        ev = pop_exp(); checks++; if (open !== ev) begin errors++; $display("FAIL ar_default_code: got %0d expected %0d", open, ev); end
        wait_idle("ar");
    endtask

    initial begin
        test_reset();
        test_open();
        test_lockout();
        test_reprogram();
        test_setpw_timeout();
        test_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
